// File: rtl/match_controller.sv
// rtl/match_controller.sv - Pong match sequencer: serve delay, scoring, pause and winner
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 25175000,
  parameter int CNT_W       = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       p1_win,
  input  logic       p2_win,
  output logic       done,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic       serve_dir,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSED    = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0]       WIN_L    = WIN_SCORE[3:0];
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_p1, w_p1_nxt, r_p2, w_p2_nxt;
  logic [1:0]       r_winner, w_winner_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_done;
  logic             r_start_q, r_pause_q, r_p1_q, r_p2_q;

  // Only the first cycle of each input level acts; held levels are ignored.
  logic w_start_rise, w_pause_rise, w_p1_rise, w_p2_rise;
  assign w_start_rise = start  & ~r_start_q;
  assign w_pause_rise = pause  & ~r_pause_q;
  assign w_p1_rise    = p1_win & ~r_p1_q;
  assign w_p2_rise    = p2_win & ~r_p2_q;

  logic [3:0] w_p1_inc, w_p2_inc;
  assign w_p1_inc = r_p1 + 4'd1;
  assign w_p2_inc = r_p2 + 4'd1;

  // Next-state and next-value logic for the match sequence.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    w_winner_nxt = r_winner;
    w_dir_nxt    = r_dir;
    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_rise) begin
          w_p1_nxt     = 4'd0;
          w_p2_nxt     = 4'd0;
          w_winner_nxt = 2'b00;
          w_dir_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SERVE;
        end
      end
      S_SERVE: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PLAY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PLAY: begin
        // A win outranks a same-cycle pause; a simultaneous double win is a replay.
        if (w_p1_rise && w_p2_rise) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SERVE;
        end else if (w_p1_rise) begin
          w_p1_nxt = w_p1_inc;
          if (w_p1_inc == WIN_L) begin
            w_winner_nxt = 2'b01;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_dir_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SERVE;
          end
        end else if (w_p2_rise) begin
          w_p2_nxt = w_p2_inc;
          if (w_p2_inc == WIN_L) begin
            w_winner_nxt = 2'b10;
            w_state_nxt  = S_GAME_OVER;
          end else begin
            w_dir_nxt   = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_SERVE;
          end
        end else if (w_pause_rise) begin
          w_state_nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (w_pause_rise) w_state_nxt = S_PLAY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, score and edge-detect registers; done follows the next state so it changes with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_p1      <= 4'd0;
      r_p2      <= 4'd0;
      r_winner  <= 2'b00;
      r_dir     <= 1'b0;
      r_done    <= 1'b1;
      r_start_q <= 1'b0;
      r_pause_q <= 1'b0;
      r_p1_q    <= 1'b0;
      r_p2_q    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_p1      <= w_p1_nxt;
      r_p2      <= w_p2_nxt;
      r_winner  <= w_winner_nxt;
      r_dir     <= w_dir_nxt;
      r_done    <= (w_state_nxt != S_PLAY);
      r_start_q <= start;
      r_pause_q <= pause;
      r_p1_q    <= p1_win;
      r_p2_q    <= p2_win;
    end
  end

  assign done      = r_done;
  assign p1_score  = r_p1;
  assign p2_score  = r_p2;
  assign winner    = r_winner;
  assign serve_dir = r_dir;
  assign state_o   = r_state;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - self-checking bench for match_controller
module tb_match_controller;
  localparam int WS = 3;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst, start, pause, p1_win, p2_win;
  logic       done, serve_dir;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;
  logic [2:0] state_o;

  match_controller #(.WIN_SCORE(WS), .SERVE_DELAY(SD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .p1_win(p1_win), .p2_win(p2_win), .done(done),
    .p1_score(p1_score), .p2_score(p2_score), .winner(winner),
    .serve_dir(serve_dir), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 idle, 1 serve, 2 play, 3 paused, 4 game over.
  int m_mode, m_p1, m_p2, m_win, m_dir, m_left;
  bit m_ps, m_pp, m_p1p, m_p2p;

  task automatic model_reset();
    m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_left = 0;
    m_ps = 0; m_pp = 0; m_p1p = 0; m_p2p = 0;
  endtask

  task automatic model_step();
    bit rs, rp, r1, r2;
    rs = start && !m_ps; rp = pause && !m_pp;
    r1 = p1_win && !m_p1p; r2 = p2_win && !m_p2p;
    if (m_mode == 0 || m_mode == 4) begin
      if (rs) begin
        m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 0; m_mode = 1; m_left = SD;
      end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 2;
    end else if (m_mode == 2) begin
      if (r1 && r2) begin
        m_mode = 1; m_left = SD;
      end else if (r1 || r2) begin
        if (r1) m_p1 = m_p1 + 1; else m_p2 = m_p2 + 1;
        if ((r1 ? m_p1 : m_p2) == WS) begin
          m_win = r1 ? 1 : 2; m_mode = 4;
        end else begin
          m_dir = r1 ? 1 : 0; m_mode = 1; m_left = SD;
        end
      end else if (rp) begin
        m_mode = 3;
      end
    end else if (m_mode == 3) begin
      if (rp) m_mode = 2;
    end
    m_ps = start; m_pp = pause; m_p1p = p1_win; m_p2p = p2_win;
  endtask

  function automatic logic [14:0] model_vec();
    return {(m_mode != 2), 4'(m_p1), 4'(m_p2), 2'(m_win), 1'(m_dir), 3'(m_mode)};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 0; pause = 0; p1_win = 0; p2_win = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycles(10);
    n_cmp++;
    if ({state_o, done, p1_score, p2_score, winner} !== {3'd0, 1'b1, 8'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL reset_idle: got st=%0d done=%b sc=%0d/%0d win=%b want st=0 done=1 sc=0/0 win=00",
               state_o, done, p1_score, p2_score, winner);
    end
  endtask

  task automatic test_serve_len();
    start = 1; cycle(); start = 0;
    for (int i = 0; i < SD; i++) begin
      n_cmp++;
      if (state_o !== 3'd1 || done !== 1'b1) begin
        n_bad++;
        $display("FAIL serve_cycle%0d: got st=%0d done=%b want st=1 done=1", i, state_o, done);
      end
      cycle();
    end
    n_cmp++;
    if (state_o !== 3'd2 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL serve_to_play: got st=%0d done=%b want st=2 done=0", state_o, done);
    end
  endtask

  task automatic test_held_win();
    p1_win = 1; cycle();
    n_cmp++;
    if (p1_score !== 4'd1 || serve_dir !== 1'b1 || state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL held_win_first: got p1=%0d dir=%b st=%0d want p1=1 dir=1 st=1", p1_score, serve_dir, state_o);
    end
    cycles(SD - 1);
    n_cmp++;
    if (state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL held_win_serve: got st=%0d want 1", state_o);
    end
    cycles(16);
    n_cmp++;
    if (p1_score !== 4'd1 || state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL held_win_level: got p1=%0d st=%0d want p1=1 st=2", p1_score, state_o);
    end
    p1_win = 0; cycle();
  endtask

  task automatic test_game_over();
    for (int k = 1; k <= WS; k++) begin
      p2_win = 1; cycle(); p2_win = 0;
      n_cmp++;
      if (p2_score !== 4'(k)) begin
        n_bad++;
        $display("FAIL p2_point%0d: got %0d want %0d", k, p2_score, k);
      end
      if (k < WS) cycles(SD);
    end
    n_cmp++;
    if ({winner, state_o, done} !== {2'b10, 3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL game_over: got win=%b st=%0d done=%b want win=10 st=4 done=1", winner, state_o, done);
    end
    p2_win = 1; cycle(); p2_win = 0; cycle();
    n_cmp++;
    if (p2_score !== 4'd3 || p1_score !== 4'd1) begin
      n_bad++;
      $display("FAIL over_hold: got sc=%0d/%0d want 1/3", p1_score, p2_score);
    end
    start = 1; cycle(); start = 0;
    n_cmp++;
    if ({p1_score, p2_score, winner, state_o} !== {8'd0, 2'b00, 3'd1}) begin
      n_bad++;
      $display("FAIL restart: got sc=%0d/%0d win=%b st=%0d want 0/0 00 1", p1_score, p2_score, winner, state_o);
    end
    cycles(SD);
  endtask

  task automatic test_pause();
    pause = 1; cycle(); pause = 0;
    n_cmp++;
    if (state_o !== 3'd3 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_enter: got st=%0d done=%b want st=3 done=1", state_o, done);
    end
    p1_win = 1; cycle(); p1_win = 0; cycle();
    n_cmp++;
    if (p1_score !== 4'd0 || state_o !== 3'd3) begin
      n_bad++;
      $display("FAIL pause_win_ignored: got p1=%0d st=%0d want p1=0 st=3", p1_score, state_o);
    end
    pause = 1; cycle(); pause = 0;
    n_cmp++;
    if (state_o !== 3'd2 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL pause_exit: got st=%0d done=%b want st=2 done=0", state_o, done);
    end
    p1_win = 1; pause = 1; cycle(); p1_win = 0; pause = 0;
    n_cmp++;
    if (p1_score !== 4'd1 || state_o !== 3'd1 || serve_dir !== 1'b1) begin
      n_bad++;
      $display("FAIL win_over_pause: got p1=%0d st=%0d dir=%b want p1=1 st=1 dir=1", p1_score, state_o, serve_dir);
    end
    cycles(SD);
  endtask

  task automatic test_double_and_reset();
    p1_win = 1; p2_win = 1; cycle(); p1_win = 0; p2_win = 0;
    n_cmp++;
    if ({p1_score, p2_score, state_o, serve_dir} !== {4'd1, 4'd0, 3'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL double_win: got sc=%0d/%0d st=%0d dir=%b want 1/0 st=1 dir=1", p1_score, p2_score, state_o, serve_dir);
    end
    cycles(2);
    #2 rst = 1'b1; model_reset();
    #1;
    n_cmp++;
    if ({state_o, done, p1_score, p2_score, serve_dir} !== {3'd0, 1'b1, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got st=%0d done=%b sc=%0d/%0d dir=%b want st=0 done=1 0/0 dir=0",
               state_o, done, p1_score, p2_score, serve_dir);
    end
    start = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    n_cmp++;
    if (state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL held_start_after_reset: got st=%0d want 1", state_o);
    end
    cycles(SD - 1);
    n_cmp++;
    if (state_o !== 3'd1) begin
      n_bad++;
      $display("FAIL reset_cnt_clear: got st=%0d want 1", state_o);
    end
    cycle();
    n_cmp++;
    if (state_o !== 3'd2) begin
      n_bad++;
      $display("FAIL reset_serve_end: got st=%0d want 2", state_o);
    end
    start = 0;
  endtask

  task automatic test_random();
    logic [14:0] dv;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      start  = ($urandom_range(0, 99) < 4);
      pause  = ($urandom_range(0, 99) < 8);
      p1_win = ($urandom_range(0, 99) < 30);
      p2_win = ($urandom_range(0, 99) < 30);
      cycle();
      dv = {done, p1_score, p2_score, winner, serve_dir, state_o};
      n_cmp++;
      if (dv !== model_vec()) begin
        n_bad++;
        $display("FAIL random_cyc%0d: dut=%h model=%h", c, dv, model_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; pause = 0; p1_win = 0; p2_win = 0;
    test_reset();
    test_serve_len();
    test_held_win();
    test_game_over();
    test_pause();
    test_double_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
